// File: rtl/dense_requant_sequencer_pkg.sv
// Shared types and constants for the dense-layer BN/ReLU6 requantization sequencer.
package dense_pkg;

  localparam int ACC_W         = 32;   // signed accumulator width
  localparam int ADDR_W        = 8;    // accumulator / shift-ROM address width
  localparam int OUT_W         = 8;    // unsigned activation width
  localparam int SHIFT_W       = 8;    // signed per-neuron shift width
  localparam int NUM_OUT_DEF   = 128;  // default neurons per run
  localparam int RELU6_MAX_Q44 = 96;   // 6.0 in Q4.4, the ReLU6 ceiling
  localparam int MAX_RSHIFT    = 31;   // right shifts are capped here
  localparam int MAX_LSHIFT    = 7;    // left shifts are capped here

  // Sequencer states; exported on the debug port so checkers can follow the FSM.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CALC  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/dense_requant_sequencer_if.sv
// Control, memory-read and output-stream bundle of the requant sequencer.
// Output stream handshake: a beat transfers on a rising clk edge where
// out_valid && out_ready. Once out_valid is high, out_data/out_index hold
// until that transfer; out_ready while out_valid is low has no effect.
interface dense_requant_sequencer_if;
  import dense_pkg::*;

  // run control
  logic                      start;
  logic                      busy;
  logic                      done;
  // accumulator buffer (1-cycle read latency)
  logic                      acc_rd_en;
  logic [ADDR_W-1:0]         acc_rd_addr;
  logic signed [ACC_W-1:0]   acc_rd_data;
  // shift ROM (combinational)
  logic [ADDR_W-1:0]         shift_addr;
  logic signed [SHIFT_W-1:0] shift_data;
  // activation stream
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_W-1:0]          out_data;
  logic [ADDR_W-1:0]         out_index;
  // per-run statistics
  logic [ADDR_W-1:0]         clip_cnt;

  // sequencer side
  modport master (
    input  start, acc_rd_data, shift_data, out_ready,
    output busy, done, acc_rd_en, acc_rd_addr, shift_addr,
           out_valid, out_data, out_index, clip_cnt
  );

  // environment side (buffers, downstream consumer, controller)
  modport slave (
    output start, acc_rd_data, shift_data, out_ready,
    input  busy, done, acc_rd_en, acc_rd_addr, shift_addr,
           out_valid, out_data, out_index, clip_cnt
  );

endinterface

// File: rtl/dense_requant_sequencer_requant.sv
// Combinational requantizer: rounded saturating arithmetic shift, then ReLU6 clamp.
module requant_relu6_unit
  import dense_pkg::*;
(
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic signed [SHIFT_W-1:0] i_shift,
  output logic [OUT_W-1:0]          o_y,
  output logic                      o_clipped
);

  localparam logic signed [ACC_W+7:0] W_MAX = (ACC_W+8)'(RELU6_MAX_Q44);

  logic [4:0]              w_r;      // right shift amount, 1..31
  logic [SHIFT_W:0]        w_neg;    // magnitude of a negative shift (9 bits so -128 fits)
  logic [2:0]              w_l;      // left shift amount, 1..7
  logic [ACC_W:0]          w_round;  // half-LSB rounding constant
  logic signed [ACC_W:0]   w_sum;    // one extra bit so rounding never wraps
  logic signed [ACC_W:0]   w_shr;
  logic signed [ACC_W+7:0] w_wide;   // common signed result before the clamp

  // Shift/round into a wide signed value, then clamp to [0, RELU6_MAX]
  always_comb begin
    w_r     = (i_shift > SHIFT_W'(MAX_RSHIFT)) ? 5'(MAX_RSHIFT) : i_shift[4:0];
    w_neg   = -{i_shift[SHIFT_W-1], i_shift};
    w_l     = (w_neg > (SHIFT_W+1)'(MAX_LSHIFT)) ? 3'(MAX_LSHIFT) : w_neg[2:0];
    w_round = {{ACC_W{1'b0}}, 1'b1} << (w_r - 5'd1);
    w_sum   = $signed({i_acc[ACC_W-1], i_acc}) + $signed(w_round);
    w_shr   = w_sum >>> w_r;

    if (i_shift > 0) begin
      w_wide = {{7{w_shr[ACC_W]}}, w_shr};
    end else if (i_shift == 0) begin
      w_wide = {{8{i_acc[ACC_W-1]}}, i_acc};
    end else begin
      w_wide = {{8{i_acc[ACC_W-1]}}, i_acc} <<< w_l;
    end

    o_y       = '0;
    o_clipped = 1'b0;
    if (w_wide[ACC_W+7]) begin
      o_y = '0;
    end else if (w_wide > W_MAX) begin
      o_y       = OUT_W'(RELU6_MAX_Q44);
      o_clipped = 1'b1;
    end else begin
      o_y = w_wide[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/dense_requant_sequencer.sv
// Walks NUM_OUT neurons: read accumulator + shift, requantize, stream one activation each.
module dense_requant_sequencer
  import dense_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dense_requant_sequencer_if.master bus,
  output state_t                    o_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUT - 1);

  state_t                    r_state;
  logic [ADDR_W-1:0]         r_idx;
  logic [ADDR_W-1:0]         r_acc_addr;
  logic [ADDR_W-1:0]         r_shift_addr;
  logic [ADDR_W-1:0]         r_out_index;
  logic [ADDR_W-1:0]         r_clip_cnt;
  logic [OUT_W-1:0]          r_out_data;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_rd_en;
  logic                      r_out_valid;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [SHIFT_W-1:0] r_shift;
  logic [OUT_W-1:0]          w_y;
  logic                      w_clipped;

  requant_relu6_unit u_requant (
    .i_acc     (r_acc),
    .i_shift   (r_shift),
    .o_y       (w_y),
    .o_clipped (w_clipped)
  );

  // Sequencer FSM; every output is a register updated on the transition into its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_acc_addr   <= '0;
      r_shift_addr <= '0;
      r_out_index  <= '0;
      r_clip_cnt   <= '0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_acc        <= '0;
      r_shift      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_idx        <= '0;
            r_clip_cnt   <= '0;
            r_busy       <= 1'b1;
            r_rd_en      <= 1'b1;
            r_acc_addr   <= '0;
            r_shift_addr <= '0;
            r_state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_rd_en <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_acc   <= bus.acc_rd_data;
          r_shift <= bus.shift_data;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_out_data  <= w_y;
          r_out_index <= r_idx;
          r_out_valid <= 1'b1;
          if (w_clipped && (r_clip_cnt != '1)) begin
            r_clip_cnt <= r_clip_cnt + 1'b1;
          end
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx        <= r_idx + 1'b1;
              r_acc_addr   <= r_idx + 1'b1;
              r_shift_addr <= r_idx + 1'b1;
              r_rd_en      <= 1'b1;
              r_state      <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.acc_rd_en   = r_rd_en;
  assign bus.acc_rd_addr = r_acc_addr;
  assign bus.shift_addr  = r_shift_addr;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_index   = r_out_index;
  assign bus.clip_cnt    = r_clip_cnt;
  assign o_state         = r_state;

endmodule

// File: doc/dense_requant_sequencer.md
Name: dense_requant_sequencer

Overview:
- Sequences BN/ReLU6 requantization of a dense layer's output neurons (default 128).
- For each neuron it reads the 32-bit accumulator from the accumulator buffer and the per-neuron shift from the layer's shift ROM.
- It applies a rounded, saturating arithmetic shift, then a ReLU6 clamp.
- Each 8-bit activation is streamed downstream over a valid/ready handshake.
- It sits between the dense MAC array's accumulator buffer and the next layer's input buffer.

Parameters:
- NUM_OUT, 128, number of output neurons processed per run
- ACC_W, 32, accumulator width (signed)
- ADDR_W, 8, width of the accumulator and shift-ROM addresses
- OUT_W, 8, output activation width (unsigned)
- RELU6_MAX, 96, quantized value of 6.0 (Q4.4); upper clamp

Ports:
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse that begins a run; ignored while busy
- busy, out, 1, high from the cycle after an accepted start until done
- done, out, 1, one-cycle pulse after the last neuron is handed off
- acc_rd_en, out, 1, accumulator buffer read strobe
- acc_rd_addr, out, ADDR_W, neuron index to the accumulator buffer
- acc_rd_data, in, ACC_W, signed accumulator; valid 1 cycle after acc_rd_en
- shift_addr, out, ADDR_W, index to the shift ROM (combinational ROM)
- shift_data, in, 8, signed shift: positive = right, negative = left
- out_valid, out, 1, activation valid
- out_ready, in, 1, downstream ready
- out_data, out, OUT_W, clamped activation
- out_index, out, ADDR_W, neuron index of out_data
- clip_cnt, out, ADDR_W, count of neurons clamped at RELU6_MAX this run

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - All outputs 0: busy, done, acc_rd_en, out_valid, acc_rd_addr, shift_addr, out_data, out_index, clip_cnt.
  - idx=0.
- FSM states: IDLE, FETCH, WAIT, CALC, OUT, DONE.
- IDLE: on start=1, clear idx and clip_cnt, then go to FETCH.
- FETCH: assert acc_rd_en for 1 cycle with acc_rd_addr=idx. shift_addr=idx and is held through CALC. Go to WAIT.
- WAIT: acc_rd_data and shift_data are now valid. Capture both into registers. Go to CALC.
- CALC: compute y from the captured values (arithmetic rules below), register out_data=y and out_index=idx, then go to OUT.
- OUT: out_valid=1.
  - out_data and out_index stay stable until out_ready=1.
  - On a handshake: out_valid drops the next cycle.
  - If idx==NUM_OUT-1, go to DONE; otherwise increment idx and go to FETCH.
- DONE: done=1 for 1 cycle, busy=0 afterwards, return to IDLE.
- Throughput: 4 cycles per neuron when out_ready is held high.
- Arithmetic, with s = signed shift_data:
  - s>0: r = min(s,31). y = (acc + (1<<(r-1))) >>> r, computed in ACC_W+1 bits (round half up, no wrap).
  - s=0: y = acc.
  - s<0: l = min(-s,7). y = acc <<< l, computed in ACC_W+8 bits.
  - ReLU6: y<0 gives 0. y>RELU6_MAX gives RELU6_MAX and clip_cnt+1 (saturates at all-ones). Otherwise y[OUT_W-1:0].
- Boundary conditions:
  - start while busy or in DONE: ignored; no restart.
  - out_ready high before out_valid: no effect.
  - Reset mid-run: immediate abort, all state cleared, no done pulse.
  - idx never wraps; it stops at NUM_OUT-1.
  - clip_cnt stays valid after done until the next accepted start.

Decomposition:
- Shared package (dense_pkg) holds:
  - the state enum;
  - constants ACC_W, OUT_W, RELU6_MAX_Q44=96, MAX_RSHIFT=31, MAX_LSHIFT=7.
- One natural sub-module: requant_relu6_unit, purely combinational.
  - Inputs: acc, shift. Outputs: y, clipped flag.
  - The sequencer registers its output in CALC.

Test Plan:
- acc[0]=100, shift[0]=0x02, NUM_OUT=1, out_ready=1 -> out_data=25, out_index=0, done 1 cycle after handshake, clip_cnt=0.
- acc=-50, shift=0x2e -> out_data=0; acc=5, shift=0xfd(-3) -> out_data=40; acc=0x7fffffff, shift=0x7f -> out_data=1.
- acc=1000, shift=0x02 -> out_data=96, clip_cnt=1.
- Full 128-neuron run with random data, out_ready=1 -> 128 handshakes with indices 0..127 in order, matches golden model, ~512 cycles, single done.
- out_ready held 0 for 5 cycles during OUT -> out_valid and out_data stable throughout; no acc_rd_en issued until the handshake.
- start pulse at neuron 10 -> ignored. rst_n=0 at neuron 40 -> all outputs 0 immediately, no done. A new start then runs from index 0.
